// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM operand loader: bank state encoding,
// default frame geometry and width helpers.
package gemm_pkg;

    localparam int GEMM_LEN = 32;
    localparam int GEMM_DW  = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Slot index width; kept at least one bit so LEN=1 still elaborates.
    function automatic int idx_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic int len_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/gemm_operand_bank.sv
// One operand bank: LEN vector/matrix slots, fill count and EMPTY/FILLING/FULL
// state. Slots at or above the count read as zero while the bank is presented.
module gemm_operand_bank
    import gemm_pkg::*;
#(
    parameter int LEN = GEMM_LEN,
    parameter int DW  = GEMM_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [idx_w(LEN)-1:0]     wr_idx,
    input  logic signed [DW-1:0]      wr_vec,
    input  logic signed [DW-1:0]      wr_mat,
    input  logic                      wr_commit,
    input  logic                      rd_done,
    output bank_state_e               state,
    output logic [len_w(LEN)-1:0]     len,
    output logic [LEN*DW-1:0]         vec_flat,
    output logic [LEN*DW-1:0]         mat_flat
);

    localparam int IW = idx_w(LEN);
    localparam int LW = len_w(LEN);

    logic signed [DW-1:0] vec_mem_q [LEN];
    logic signed [DW-1:0] mat_mem_q [LEN];
    bank_state_e          state_q, state_d;
    logic [LW-1:0]        count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            BANK_EMPTY, BANK_FILLING: begin
                if (wr_en) begin
                    count_d = LW'(wr_idx) + LW'(1);
                    state_d = wr_commit ? BANK_FULL : BANK_FILLING;
                end
            end
            BANK_FULL: begin
                if (rd_done) begin
                    state_d = BANK_EMPTY;
                end
            end
            default: state_d = BANK_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BANK_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: the count mask hides anything stale.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            vec_mem_q[wr_idx] <= wr_vec;
            mat_mem_q[wr_idx] <= wr_mat;
        end
    end

    always_comb begin
        state = state_q;
        len   = (state_q == BANK_FULL) ? count_q : '0;
    end

    for (genvar i = 0; i < LEN; i++) begin : g_slot
        assign vec_flat[i*DW +: DW] = (LW'(i) < len) ? vec_mem_q[i] : '0;
        assign mat_flat[i*DW +: DW] = (LW'(i) < len) ? mat_mem_q[i] : '0;
    end

endmodule

// File: rtl/gemm_operand_loader.sv
// Collects streamed vector/matrix element pairs into zero-padded frames for the
// dot-product stage. Define GEMM_LOADER_DOUBLE_BUF_EN for ping-pong banks.
module gemm_operand_loader
    import gemm_pkg::*;
#(
    parameter int LEN = GEMM_LEN,
    parameter int DW  = GEMM_DW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_vec,
    input  logic [DW-1:0]              in_mat,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LEN*DW-1:0]          vec_flat,
    output logic [LEN*DW-1:0]          mat_flat,
    output logic [$clog2(LEN+1)-1:0]   out_len
);

    localparam int IW = idx_w(LEN);
    localparam int LW = len_w(LEN);
`ifdef GEMM_LOADER_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          run_q, run_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          fill_sel_q, fill_sel_d;
    logic          out_sel_q, out_sel_d;
    logic          accept, commit, drain;

    bank_state_e       bank_state [2];
    logic [LW-1:0]     bank_len   [2];
    logic [LEN*DW-1:0] bank_vec   [2];
    logic [LEN*DW-1:0] bank_mat   [2];

    // Readiness comes only from registered state, never from in_valid or out_ready.
    always_comb begin
        run_d      = 1'b1;
        in_ready   = run_q && (bank_state[fill_sel_q] != BANK_FULL);
        out_valid  = (bank_state[out_sel_q] == BANK_FULL);
        accept     = in_valid && in_ready;
        commit     = accept && (in_last || (idx_q == IW'(LEN - 1)));
        drain      = out_valid && out_ready;
        idx_d      = idx_q;
        fill_sel_d = fill_sel_q;
        out_sel_d  = out_sel_q;
        if (accept) begin
            idx_d = commit ? '0 : idx_q + IW'(1);
        end
`ifdef GEMM_LOADER_DOUBLE_BUF_EN
        if (commit) begin
            fill_sel_d = ~fill_sel_q;
        end
        if (drain) begin
            out_sel_d = ~out_sel_q;
        end
`endif
        vec_flat = bank_vec[out_sel_q];
        mat_flat = bank_mat[out_sel_q];
        out_len  = bank_len[out_sel_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            idx_q      <= '0;
            fill_sel_q <= 1'b0;
            out_sel_q  <= 1'b0;
        end else begin
            run_q      <= run_d;
            idx_q      <= idx_d;
            fill_sel_q <= fill_sel_d;
            out_sel_q  <= out_sel_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NB) begin : g_inst
            gemm_operand_bank #(
                .LEN (LEN),
                .DW  (DW)
            ) u_bank (
                .clk       (clk),
                .rst_n     (rst_n),
                .wr_en     (accept && (fill_sel_q == 1'(b))),
                .wr_idx    (idx_q),
                .wr_vec    (in_vec),
                .wr_mat    (in_mat),
                .wr_commit (commit),
                .rd_done   (drain && (out_sel_q == 1'(b))),
                .state     (bank_state[b]),
                .len       (bank_len[b]),
                .vec_flat  (bank_vec[b]),
                .mat_flat  (bank_mat[b])
            );
        end else begin : g_tie
            // Unbuilt ping-pong partner; never selected in single-bank builds.
            assign bank_state[b] = BANK_EMPTY;
            assign bank_len[b]   = '0;
            assign bank_vec[b]   = '0;
            assign bank_mat[b]   = '0;
        end
    end

endmodule
